// File: rtl/oab_pkg.sv
// rtl/oab_pkg.sv - shared types and constants for the one-armed-bandit console
package oab_pkg;

  localparam int MAX_BET               = 10;
  localparam int BET_W                 = 4;
  localparam int PAYOUT_W              = 4;
  localparam int DEFAULT_JACKPOT_BONUS = 100;

  typedef enum logic [2:0] {
    IDLE,
    ROLL,
    WAIT,
    SETTLE,
    DISPENSE
  } oab_ctrl_state_t;

endpackage

// File: rtl/oab_credit_alu.sv
// rtl/oab_credit_alu.sv - saturating credit update shared by every controller state
module oab_credit_alu
  import oab_pkg::*;
#(
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 255
) (
  input  logic [CREDIT_W-1:0] credit_i,
  input  logic [BET_W-1:0]    debit_i,
  input  logic                dec1_i,
  input  logic                coin_i,
  input  logic [CREDIT_W+1:0] amt_i,
  output logic [CREDIT_W-1:0] next_credit_o,
  output logic                coin_rejected_o
);

  localparam int SUM_W = CREDIT_W + 2;
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX_CREDIT);

  logic signed [SUM_W-1:0] sum;
  logic        [SUM_W-1:0] clamped;

  // The coin is judged against the balance it would join, after all other terms settle.
  always_comb begin
    sum = $signed({2'b00, credit_i})
        - $signed({{(SUM_W-BET_W){1'b0}}, debit_i})
        - $signed({{(SUM_W-1){1'b0}}, dec1_i})
        + $signed(amt_i);
    if (sum < 0) begin
      clamped = '0;
    end else if (sum > MAX_S) begin
      clamped = MAX_S;
    end else begin
      clamped = sum;
    end
    coin_rejected_o = coin_i & (clamped == SUM_W'(MAX_CREDIT));
    next_credit_o   = CREDIT_W'(clamped) + CREDIT_W'(coin_i & ~coin_rejected_o);
  end

endmodule

// File: rtl/oab_credit_ctrl.sv
// rtl/oab_credit_ctrl.sv - player console: credit keeping, bet/roll/settle, cash-out dispense
module oab_credit_ctrl
  import oab_pkg::*;
#(
  parameter int CREDIT_W      = 8,
  parameter int MAX_CREDIT    = 255,
  parameter int RESULT_LAT    = 1,
  parameter int JACKPOT_BONUS = DEFAULT_JACKPOT_BONUS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_in,
  input  logic [BET_W-1:0]    bet_req,
  input  logic                play,
  input  logic                cash_out,
  input  logic                jackpot,
  input  logic [PAYOUT_W-1:0] payout,
  output logic                roll,
  output logic [BET_W-1:0]    bet,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                win,
  output logic [CREDIT_W-1:0] last_win,
  output logic                coin_out,
  output logic                coin_reject,
  output logic                play_reject
);

  localparam int SUM_W = CREDIT_W + 2;
  localparam int CNT_W = (RESULT_LAT > 2) ? $clog2(RESULT_LAT) : 1;

  oab_ctrl_state_t     state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, last_win_q, last_win_d;
  logic [BET_W-1:0]    bet_q, bet_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                win_q, win_d, play_rej_q, play_rej_d, coin_rej_q;

  logic                cash_go, play_go, play_legal, dec1;
  logic [BET_W-1:0]    debit;
  logic [SUM_W-1:0]    amt_full, amt;
  logic [CREDIT_W-1:0] next_credit;
  logic                coin_rejected;

  assign play_legal = (bet_req != '0) && (bet_req <= BET_W'(MAX_BET))
                   && (CREDIT_W'(bet_req) <= credit_q);
  assign cash_go    = (state_q == IDLE) && cash_out && (credit_q != '0);
  assign play_go    = (state_q == IDLE) && !cash_go && play;
  assign amt_full   = SUM_W'(payout) + (jackpot ? SUM_W'(JACKPOT_BONUS) : '0);

  // ALU operands kept outside the FSM process so the next-state logic can use next_credit.
  assign debit = (play_go && play_legal) ? bet_req : '0;
  assign dec1  = (state_q == DISPENSE) && (credit_q != '0);
  assign amt   = (state_q == SETTLE) ? amt_full : '0;

  oab_credit_alu #(
    .CREDIT_W  (CREDIT_W),
    .MAX_CREDIT(MAX_CREDIT)
  ) u_alu (
    .credit_i       (credit_q),
    .debit_i        (debit),
    .dec1_i         (dec1),
    .coin_i         (coin_in),
    .amt_i          (amt),
    .next_credit_o  (next_credit),
    .coin_rejected_o(coin_rejected)
  );

  always_comb begin
    state_d    = state_q;
    bet_d      = bet_q;
    last_win_d = last_win_q;
    wait_cnt_d = wait_cnt_q;
    win_d      = 1'b0;
    play_rej_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cash_go) begin
          state_d = DISPENSE;
        end else if (play_go) begin
          if (play_legal) begin
            bet_d   = bet_req;
            state_d = ROLL;
          end else begin
            play_rej_d = 1'b1;
          end
        end
      end
      ROLL: begin
        wait_cnt_d = '0;
        state_d    = (RESULT_LAT > 1) ? WAIT : SETTLE;
      end
      WAIT: begin
        if (wait_cnt_q == CNT_W'(RESULT_LAT - 2)) begin
          state_d = SETTLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        last_win_d = (amt_full > SUM_W'(MAX_CREDIT)) ? CREDIT_W'(MAX_CREDIT)
                                                     : CREDIT_W'(amt_full);
        win_d      = (amt_full != '0);
        state_d    = IDLE;
      end
      DISPENSE: begin
        if (next_credit == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      bet_q      <= '0;
      last_win_q <= '0;
      wait_cnt_q <= '0;
      win_q      <= 1'b0;
      play_rej_q <= 1'b0;
      coin_rej_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= next_credit;
      bet_q      <= bet_d;
      last_win_q <= last_win_d;
      wait_cnt_q <= wait_cnt_d;
      win_q      <= win_d;
      play_rej_q <= play_rej_d;
      coin_rej_q <= coin_rejected;
    end
  end

  assign roll        = (state_q == ROLL);
  assign busy        = (state_q != IDLE);
  assign coin_out    = dec1;
  assign bet         = bet_q;
  assign credit      = credit_q;
  assign last_win    = last_win_q;
  assign win         = win_q;
  assign play_reject = play_rej_q;
  assign coin_reject = coin_rej_q;

endmodule

// File: tb/tb_oab_credit_ctrl.sv
// tb/tb_oab_credit_ctrl.sv - scoreboard bench for oab_credit_ctrl at result latency 1 and 3
module tb_oab_credit_ctrl;

  localparam int MAXC  = 255;
  localparam int BONUS = 100;

  typedef struct {
    int cyc;
    int credit;
    int bet;
    int last_win;
    bit busy, roll, win, cout, crej, prej;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic       rst_s[2], coin_s[2], play_s[2], cash_s[2], jp_s[2];
  logic [3:0] breq_s[2], pay_s[2];
  logic       roll_s[2], busy_s[2], win_s[2], cout_s[2], crej_s[2], prej_s[2];
  logic [3:0] bet_s[2];
  logic [7:0] credit_s[2], lastw_s[2];

  oab_credit_ctrl #(.CREDIT_W(8), .MAX_CREDIT(MAXC), .RESULT_LAT(1), .JACKPOT_BONUS(BONUS)) dut1 (
    .clk(clk), .rst(rst_s[0]), .coin_in(coin_s[0]), .bet_req(breq_s[0]), .play(play_s[0]),
    .cash_out(cash_s[0]), .jackpot(jp_s[0]), .payout(pay_s[0]), .roll(roll_s[0]), .bet(bet_s[0]),
    .credit(credit_s[0]), .busy(busy_s[0]), .win(win_s[0]), .last_win(lastw_s[0]),
    .coin_out(cout_s[0]), .coin_reject(crej_s[0]), .play_reject(prej_s[0]));

  oab_credit_ctrl #(.CREDIT_W(8), .MAX_CREDIT(MAXC), .RESULT_LAT(3), .JACKPOT_BONUS(BONUS)) dut3 (
    .clk(clk), .rst(rst_s[1]), .coin_in(coin_s[1]), .bet_req(breq_s[1]), .play(play_s[1]),
    .cash_out(cash_s[1]), .jackpot(jp_s[1]), .payout(pay_s[1]), .roll(roll_s[1]), .bet(bet_s[1]),
    .credit(credit_s[1]), .busy(busy_s[1]), .win(win_s[1]), .last_win(lastw_s[1]),
    .coin_out(cout_s[1]), .coin_reject(crej_s[1]), .play_reject(prej_s[1]));

  int   checks = 0, errors = 0;
  rec_t q0[$], q1[$];
  int   m_credit[2], m_bet[2], m_last[2];
  bit   m_noise[2];

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int clampc(input int v);
    return (v < 0) ? 0 : ((v > MAXC) ? MAXC : v);
  endfunction

  function automatic bit rc(input int i, input int den);
    return m_noise[i] && ($urandom_range(0, den - 1) == 0);
  endfunction

  function automatic bit nz(input int i);
    return m_noise[i] && ($urandom_range(0, 1) == 1);
  endfunction

  task automatic edge_credit(input int i, input int delta, input bit coin, output bit rej);
    int pre;
    pre = clampc(m_credit[i] + delta);
    rej = 1'b0;
    if (coin) begin
      if (pre == MAXC) rej = 1'b1;
      else pre++;
    end
    m_credit[i] = pre;
  endtask

  function automatic rec_t mk(input int i, input bit busy, input bit roll, input bit win,
                              input bit cout, input bit crej, input bit prej);
    rec_t e;
    e.cyc = cyc_cnt + 1;
    e.credit = m_credit[i];
    e.bet = m_bet[i];
    e.last_win = m_last[i];
    e.busy = busy; e.roll = roll; e.win = win; e.cout = cout; e.crej = crej; e.prej = prej;
    return e;
  endfunction

  task automatic drive(input int i, input bit r_v, input bit c_v, input bit p_v, input int b_v,
                       input bit x_v, input bit j_v, input int y_v, input rec_t e);
    rst_s[i] = r_v; coin_s[i] = c_v; play_s[i] = p_v; breq_s[i] = 4'(b_v);
    cash_s[i] = x_v; jp_s[i] = j_v; pay_s[i] = 4'(y_v);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic op_reset(input int i);
    m_credit[i] = 0; m_bet[i] = 0; m_last[i] = 0;
    drive(i, 1, nz(i), nz(i), $urandom_range(0, 15), nz(i), nz(i), 9, mk(i, 0, 0, 0, 0, 0, 0));
  endtask

  // cmode: 0 no coins, 1 a coin every cycle, 2 random coins
  task automatic op_idle(input int i, input int n, input int cmode);
    bit c, rej;
    for (int k = 0; k < n; k++) begin
      c = (cmode == 1) ? 1'b1 : ((cmode == 2) ? rc(i, 3) : 1'b0);
      edge_credit(i, 0, c, rej);
      drive(i, 0, c, 0, 0, 0, nz(i), 9, mk(i, 0, 0, 0, 0, rej, 0));
    end
  endtask

  // abort > 0 asserts reset in that busy cycle (1 = roll cycle, lat+1 = sample cycle)
  task automatic op_play(input int i, input int b, input bit jp, input int pay, input int abort);
    bit c, rej;
    int amt;
    c = rc(i, 3);
    if (!(b >= 1 && b <= 10 && b <= m_credit[i])) begin
      edge_credit(i, 0, c, rej);
      drive(i, 0, c, 1, b, 0, nz(i), $urandom_range(0, 15), mk(i, 0, 0, 0, 0, rej, 1));
      return;
    end
    m_bet[i] = b;
    edge_credit(i, -b, c, rej);
    drive(i, 0, c, 1, b, 0, nz(i), $urandom_range(0, 15), mk(i, 1, 1, 0, 0, rej, 0));
    for (int idx = 1; idx <= lat(i) + 1; idx++) begin
      if (idx == abort) begin
        op_reset(i);
        return;
      end
      c = rc(i, 3);
      if (idx <= lat(i)) begin
        edge_credit(i, 0, c, rej);
        drive(i, 0, c, nz(i), $urandom_range(0, 15), nz(i), $urandom_range(0, 1) == 1,
              $urandom_range(0, 15), mk(i, 1, 0, 0, 0, rej, 0));
      end else begin
        amt = pay + (jp ? BONUS : 0);
        edge_credit(i, amt, c, rej);
        m_last[i] = clampc(amt);
        drive(i, 0, c, nz(i), $urandom_range(0, 15), nz(i), jp, pay,
              mk(i, 0, 0, amt != 0, 0, rej, 0));
      end
    end
  endtask

  // cmode: 0 no coins, 1 one coin in the first dispense cycle, 2 random coins
  task automatic op_cash(input int i, input bit with_play, input int cmode);
    bit c, rej;
    int guard;
    if (m_credit[i] == 0) begin
      op_idle(i, 1, cmode == 2 ? 2 : 0);
      return;
    end
    c = (cmode == 2) ? rc(i, 4) : 1'b0;
    edge_credit(i, 0, c, rej);
    drive(i, 0, c, with_play, $urandom_range(1, 3), 1, nz(i), 9, mk(i, 1, 0, 0, 1, rej, 0));
    guard = 0;
    while (m_credit[i] > 0 && guard < 2000) begin
      c = (cmode == 1) ? (guard == 0) : ((cmode == 2) ? rc(i, 4) : 1'b0);
      edge_credit(i, -1, c, rej);
      drive(i, 0, c, nz(i), $urandom_range(0, 15), nz(i), nz(i), 9,
            mk(i, m_credit[i] > 0, 0, 0, m_credit[i] > 0, rej, 0));
      guard++;
    end
  endtask

  task automatic rand_ops(input int i, input int n);
    int r;
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 19);
      if (r < 8)       op_play(i, $urandom_range(0, 15), $urandom_range(0, 7) == 0, $urandom_range(0, 15), 0);
      else if (r < 11) op_idle(i, $urandom_range(1, 6), 2);
      else if (r < 13) op_cash(i, $urandom_range(0, 1) == 1, 2);
      else if (r < 16) op_idle(i, $urandom_range(5, 40), 1);
      else if (r == 16) op_reset(i);
      else if (r == 17) op_play(i, $urandom_range(1, 4), $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                                $urandom_range(1, lat(i) + 1));
      else             op_play(i, $urandom_range(1, 10), $urandom_range(0, 3) == 0, $urandom_range(0, 15), 0);
    end
  endtask

  task automatic park(input int i);
    rst_s[i] = 0; coin_s[i] = 0; play_s[i] = 0; cash_s[i] = 0; jp_s[i] = 0;
    breq_s[i] = '0; pay_s[i] = '0;
  endtask

  task automatic seq0();
    m_noise[0] = 0;
    op_reset(0);
    op_idle(0, 5, 1);
    op_play(0, 3, 0, 0, 0);
    op_idle(0, 8, 1);
    op_play(0, 4, 1, 7, 0);
    op_cash(0, 0, 0);
    op_idle(0, 2, 1);
    op_play(0, 3, 0, 5, 0);
    op_play(0, 0, 0, 5, 0);
    op_idle(0, 18, 1);
    op_play(0, 11, 0, 5, 0);
    op_idle(0, 234, 1);
    op_idle(0, 2, 1);
    op_play(0, 5, 0, 0, 0);
    op_play(0, 1, 0, 15, 0);
    op_cash(0, 0, 0);
    op_idle(0, 3, 1);
    op_cash(0, 1, 1);
    m_noise[0] = 1;
    rand_ops(0, 150);
    park(0);
  endtask

  task automatic seq1();
    m_noise[1] = 0;
    op_reset(1);
    op_idle(1, 5, 1);
    op_play(1, 2, 0, 9, 2);
    op_idle(1, 6, 0);
    op_idle(1, 4, 1);
    op_play(1, 3, 1, 2, 0);
    m_noise[1] = 1;
    rand_ops(1, 80);
    park(1);
  endtask

  task automatic chk(input string nm, input int i, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %0d, expected %0d", nm, i, cyc_cnt, act, exp);
    end
  endtask

  task automatic check_rec(input int i, input rec_t e);
    if (e.cyc != cyc_cnt) chk("order", i, 32'(e.cyc), cyc_cnt);
    chk("credit", i, 32'(credit_s[i]), e.credit);
    chk("bet", i, 32'(bet_s[i]), e.bet);
    chk("last_win", i, 32'(lastw_s[i]), e.last_win);
    chk("busy", i, 32'(busy_s[i]), int'(e.busy));
    chk("roll", i, 32'(roll_s[i]), int'(e.roll));
    chk("win", i, 32'(win_s[i]), int'(e.win));
    chk("coin_out", i, 32'(cout_s[i]), int'(e.cout));
    chk("coin_reject", i, 32'(crej_s[i]), int'(e.crej));
    chk("play_reject", i, 32'(prej_s[i]), int'(e.prej));
  endtask

  always @(negedge clk) begin
    while (q0.size() > 0 && q0[0].cyc <= cyc_cnt) check_rec(0, q0.pop_front());
    while (q1.size() > 0 && q1[0].cyc <= cyc_cnt) check_rec(1, q1.pop_front());
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      park(i);
      m_credit[i] = 0; m_bet[i] = 0; m_last[i] = 0; m_noise[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    fork
      seq0();
      seq1();
    join
    @(negedge clk);
    #1;
    chk("drain", 0, 32'(q0.size()), 0);
    chk("drain", 1, 32'(q1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
